rc4_key_search_ctrl: RTL and testbench

Parametrised top-level sequencer for the RC4 brute-force key search. Steps a candidate key through a configurable range and stride, running init, KSA and decrypt/check phase engines per key via start/done handshakes. Owns the single S-RAM port and muxes it to the active phase engine. Range/stride parameters let N instances split one key space; an external stop lets a winning instance halt the others.

---
 rtl/rc4_key_search_ctrl_pkg.sv | 30 +++
 rtl/rc4_key_search_ctrl_s_port_mux.sv | 52 +++++
 rtl/rc4_key_search_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_rc4_key_search_ctrl.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_key_search_ctrl_pkg.sv
// Shared types for the RC4 key-search controller: FSM states, S-RAM phase
// select and default widths.
package key_search_pkg;

    localparam int unsigned KEY_W_DEF  = 24;
    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned DATA_W_DEF = 8;

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT_GO,
        S_INIT_WAIT,
        S_KSA_GO,
        S_KSA_WAIT,
        S_DEC_GO,
        S_DEC_WAIT,
        S_NEXT_KEY,
        S_FOUND,
        S_EXHAUSTED,
        S_ABORTED
    } state_t;

    typedef enum logic [1:0] {
        PH_NONE,
        PH_INIT,
        PH_KSA,
        PH_DEC
    } phase_t;

endpackage

// File: rtl/rc4_key_search_ctrl_s_port_mux.sv
// Combinational 3:1 mux handing the single S-RAM port to the active phase
// engine; with no phase selected the port is idle and cannot write.
module s_port_mux
    import key_search_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  phase_t            phase,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [DATA_W-1:0] init_data,
    input  logic              init_wren,
    input  logic [ADDR_W-1:0] ksa_addr,
    input  logic [DATA_W-1:0] ksa_data,
    input  logic              ksa_wren,
    input  logic [ADDR_W-1:0] dec_addr,
    input  logic [DATA_W-1:0] dec_data,
    input  logic              dec_wren,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_data,
    output logic              s_wren
);

    always_comb begin
        s_addr = '0;
        s_data = '0;
        s_wren = 1'b0;
        case (phase)
            PH_INIT: begin
                s_addr = init_addr;
                s_data = init_data;
                s_wren = init_wren;
            end
            PH_KSA: begin
                s_addr = ksa_addr;
                s_data = ksa_data;
                s_wren = ksa_wren;
            end
            PH_DEC: begin
                s_addr = dec_addr;
                s_data = dec_data;
                s_wren = dec_wren;
            end
            default: begin
                s_addr = '0;
                s_data = '0;
                s_wren = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/rc4_key_search_ctrl.sv
// RC4 brute-force key-search sequencer: walks KEY_START..KEY_LIMIT by KEY_STRIDE,
// running init/KSA/decrypt engines per key. KEY_SEARCH_PERF_EN adds perf counters.
module rc4_key_search_ctrl
    import key_search_pkg::*;
#(
    parameter int unsigned       KEY_W      = KEY_W_DEF,
    parameter int unsigned       ADDR_W     = ADDR_W_DEF,
    parameter int unsigned       DATA_W     = DATA_W_DEF,
    parameter logic [KEY_W-1:0]  KEY_START  = '0,
    parameter logic [KEY_W-1:0]  KEY_LIMIT  = KEY_W'(24'h3FFFFF),
    parameter int unsigned       KEY_STRIDE = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    input  logic              stop,
    output logic              init_start,
    output logic              ksa_start,
    output logic              dec_start,
    input  logic              init_done,
    input  logic              ksa_done,
    input  logic              dec_done,
    input  logic              dec_valid,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [DATA_W-1:0] init_data,
    input  logic              init_wren,
    input  logic [ADDR_W-1:0] ksa_addr,
    input  logic [DATA_W-1:0] ksa_data,
    input  logic              ksa_wren,
    input  logic [ADDR_W-1:0] dec_addr,
    input  logic [DATA_W-1:0] dec_data,
    input  logic              dec_wren,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_data,
    output logic              s_wren,
    output logic [KEY_W-1:0]  secret_key,
    output logic              busy,
    output logic              found,
    output logic              exhausted,
    output logic              aborted
`ifdef KEY_SEARCH_PERF_EN
    ,
    output logic [31:0]       cycle_count,
    output logic [KEY_W-1:0]  keys_tried
`endif
);

    localparam logic [KEY_W:0] STRIDE_EXT        = (KEY_W+1)'(KEY_STRIDE);
    localparam logic           START_ABOVE_LIMIT = (KEY_START > KEY_LIMIT);

    state_t          state;
    phase_t          phase;
    logic            valid_lat;
    logic            stop_pend;
    logic [KEY_W:0]  next_key;
    logic            next_over;

    // The extra top bit catches wrap-around when the stride crosses 2**KEY_W.
    assign next_key  = {1'b0, secret_key} + STRIDE_EXT;
    assign next_over = next_key[KEY_W] | (next_key[KEY_W-1:0] > KEY_LIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            secret_key <= KEY_START;
            init_start <= 1'b0;
            ksa_start  <= 1'b0;
            dec_start  <= 1'b0;
            busy       <= 1'b0;
            found      <= 1'b0;
            exhausted  <= 1'b0;
            aborted    <= 1'b0;
            valid_lat  <= 1'b0;
            stop_pend  <= 1'b0;
        end else begin
            init_start <= 1'b0;
            ksa_start  <= 1'b0;
            dec_start  <= 1'b0;
            if (busy && stop) begin
                stop_pend <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (go) begin
                        secret_key <= KEY_START;
                        found      <= 1'b0;
                        exhausted  <= 1'b0;
                        aborted    <= 1'b0;
                        valid_lat  <= 1'b0;
                        stop_pend  <= 1'b0;
                        if (START_ABOVE_LIMIT) begin
                            state     <= S_EXHAUSTED;
                            exhausted <= 1'b1;
                        end else begin
                            state      <= S_INIT_GO;
                            init_start <= 1'b1;
                            busy       <= 1'b1;
                        end
                    end
                end
                S_INIT_GO: state <= S_INIT_WAIT;
                S_INIT_WAIT: begin
                    if (init_done) begin
                        state     <= S_KSA_GO;
                        ksa_start <= 1'b1;
                    end
                end
                S_KSA_GO: state <= S_KSA_WAIT;
                S_KSA_WAIT: begin
                    if (ksa_done) begin
                        state     <= S_DEC_GO;
                        dec_start <= 1'b1;
                    end
                end
                S_DEC_GO: state <= S_DEC_WAIT;
                S_DEC_WAIT: begin
                    if (dec_done) begin
                        valid_lat <= dec_valid;
                        state     <= S_NEXT_KEY;
                    end
                end
                S_NEXT_KEY: begin
                    // A hit outranks a pending stop so a winning key is never lost.
                    if (valid_lat) begin
                        state <= S_FOUND;
                        found <= 1'b1;
                        busy  <= 1'b0;
                    end else if (stop_pend) begin
                        state   <= S_ABORTED;
                        aborted <= 1'b1;
                        busy    <= 1'b0;
                    end else if (next_over) begin
                        state     <= S_EXHAUSTED;
                        exhausted <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        secret_key <= next_key[KEY_W-1:0];
                        state      <= S_INIT_GO;
                        init_start <= 1'b1;
                    end
                end
                default: state <= state;
            endcase
        end
    end

    always_comb begin
        phase = PH_NONE;
        case (state)
            S_INIT_GO, S_INIT_WAIT: phase = PH_INIT;
            S_KSA_GO,  S_KSA_WAIT:  phase = PH_KSA;
            S_DEC_GO,  S_DEC_WAIT:  phase = PH_DEC;
            default:                phase = PH_NONE;
        endcase
    end

    s_port_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_s_port_mux (
        .phase     (phase),
        .init_addr (init_addr),
        .init_data (init_data),
        .init_wren (init_wren),
        .ksa_addr  (ksa_addr),
        .ksa_data  (ksa_data),
        .ksa_wren  (ksa_wren),
        .dec_addr  (dec_addr),
        .dec_data  (dec_data),
        .dec_wren  (dec_wren),
        .s_addr    (s_addr),
        .s_data    (s_data),
        .s_wren    (s_wren)
    );

`ifdef KEY_SEARCH_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_count <= '0;
            keys_tried  <= '0;
        end else if (state == S_IDLE && go) begin
            cycle_count <= '0;
            keys_tried  <= '0;
        end else begin
            if (busy && cycle_count != '1) begin
                cycle_count <= cycle_count + 32'd1;
            end
            if (state == S_NEXT_KEY) begin
                keys_tried <= keys_tried + KEY_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// Directed bench for rc4_key_search_ctrl: five differently configured instances
// share clk/reset, each driven by a fixed-latency phase-engine stub.
module tb_rc4_key_search_ctrl;

    localparam int NI = 5;
    localparam logic [7:0] IA = 8'h11, KA = 8'h22, DA = 8'h33;
    localparam logic [7:0] ID = 8'hA1, KD = 8'hA2, DD = 8'hA3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NI-1:0] go = '0;
    logic stop = 1'b0;
    logic [NI-1:0] init_start, ksa_start, dec_start;
    logic [NI-1:0] init_done = '0, ksa_done = '0, dec_done = '0, dec_valid = '0;
    logic [NI-1:0] s_wren, busy, found, exhausted, aborted;
    logic [7:0]    s_addr [NI];
    logic [7:0]    s_data [NI];
    logic [23:0]   skey   [NI];
    logic [3:0]    key4;
`ifdef KEY_SEARCH_PERF_EN
    logic [31:0]   cc [NI];
    logic [23:0]   kt [NI];
    logic [3:0]    kt4;
    assign kt[4] = {20'd0, kt4};
`endif
    assign skey[4] = {20'd0, key4};

    logic        hit_en  = 1'b0;
    logic [23:0] hit_key = '0;
    int          cnt [NI];
    int          ph  [NI];
    int          n_init [NI];
    int          n_ksa  [NI];
    int          n_dec  [NI];
    logic [23:0] key_log [NI][8];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [23:0] exp_start [NI] = '{24'd0, 24'd0, 24'd1, 24'd11, 24'd14};

    always #5 clk = ~clk;

    rc4_key_search_ctrl #(.KEY_W(24), .KEY_START(24'd0), .KEY_LIMIT(24'd15), .KEY_STRIDE(1)) u0 (
        .clk(clk), .reset(rst), .go(go[0]), .stop(stop),
        .init_start(init_start[0]), .ksa_start(ksa_start[0]), .dec_start(dec_start[0]),
        .init_done(init_done[0]), .ksa_done(ksa_done[0]), .dec_done(dec_done[0]), .dec_valid(dec_valid[0]),
        .init_addr(IA), .init_data(ID), .init_wren(1'b1),
        .ksa_addr(KA), .ksa_data(KD), .ksa_wren(1'b1),
        .dec_addr(DA), .dec_data(DD), .dec_wren(1'b1),
        .s_addr(s_addr[0]), .s_data(s_data[0]), .s_wren(s_wren[0]), .secret_key(skey[0]),
        .busy(busy[0]), .found(found[0]), .exhausted(exhausted[0]), .aborted(aborted[0])
`ifdef KEY_SEARCH_PERF_EN
        , .cycle_count(cc[0]), .keys_tried(kt[0])
`endif
    );

    rc4_key_search_ctrl #(.KEY_W(24), .KEY_START(24'd0), .KEY_LIMIT(24'd3), .KEY_STRIDE(1)) u1 (
        .clk(clk), .reset(rst), .go(go[1]), .stop(1'b0),
        .init_start(init_start[1]), .ksa_start(ksa_start[1]), .dec_start(dec_start[1]),
        .init_done(init_done[1]), .ksa_done(ksa_done[1]), .dec_done(dec_done[1]), .dec_valid(dec_valid[1]),
        .init_addr(IA), .init_data(ID), .init_wren(1'b1),
        .ksa_addr(KA), .ksa_data(KD), .ksa_wren(1'b1),
        .dec_addr(DA), .dec_data(DD), .dec_wren(1'b1),
        .s_addr(s_addr[1]), .s_data(s_data[1]), .s_wren(s_wren[1]), .secret_key(skey[1]),
        .busy(busy[1]), .found(found[1]), .exhausted(exhausted[1]), .aborted(aborted[1])
`ifdef KEY_SEARCH_PERF_EN
        , .cycle_count(cc[1]), .keys_tried(kt[1])
`endif
    );

    rc4_key_search_ctrl #(.KEY_W(24), .KEY_START(24'd1), .KEY_LIMIT(24'd10), .KEY_STRIDE(4)) u2 (
        .clk(clk), .reset(rst), .go(go[2]), .stop(1'b0),
        .init_start(init_start[2]), .ksa_start(ksa_start[2]), .dec_start(dec_start[2]),
        .init_done(init_done[2]), .ksa_done(ksa_done[2]), .dec_done(dec_done[2]), .dec_valid(dec_valid[2]),
        .init_addr(IA), .init_data(ID), .init_wren(1'b1),
        .ksa_addr(KA), .ksa_data(KD), .ksa_wren(1'b1),
        .dec_addr(DA), .dec_data(DD), .dec_wren(1'b1),
        .s_addr(s_addr[2]), .s_data(s_data[2]), .s_wren(s_wren[2]), .secret_key(skey[2]),
        .busy(busy[2]), .found(found[2]), .exhausted(exhausted[2]), .aborted(aborted[2])
`ifdef KEY_SEARCH_PERF_EN
        , .cycle_count(cc[2]), .keys_tried(kt[2])
`endif
    );

    rc4_key_search_ctrl #(.KEY_W(24), .KEY_START(24'd11), .KEY_LIMIT(24'd10), .KEY_STRIDE(1)) u3 (
        .clk(clk), .reset(rst), .go(go[3]), .stop(1'b0),
        .init_start(init_start[3]), .ksa_start(ksa_start[3]), .dec_start(dec_start[3]),
        .init_done(init_done[3]), .ksa_done(ksa_done[3]), .dec_done(dec_done[3]), .dec_valid(dec_valid[3]),
        .init_addr(IA), .init_data(ID), .init_wren(1'b1),
        .ksa_addr(KA), .ksa_data(KD), .ksa_wren(1'b1),
        .dec_addr(DA), .dec_data(DD), .dec_wren(1'b1),
        .s_addr(s_addr[3]), .s_data(s_data[3]), .s_wren(s_wren[3]), .secret_key(skey[3]),
        .busy(busy[3]), .found(found[3]), .exhausted(exhausted[3]), .aborted(aborted[3])
`ifdef KEY_SEARCH_PERF_EN
        , .cycle_count(cc[3]), .keys_tried(kt[3])
`endif
    );

    rc4_key_search_ctrl #(.KEY_W(4), .KEY_START(4'd14), .KEY_LIMIT(4'd15), .KEY_STRIDE(4)) u4 (
        .clk(clk), .reset(rst), .go(go[4]), .stop(1'b0),
        .init_start(init_start[4]), .ksa_start(ksa_start[4]), .dec_start(dec_start[4]),
        .init_done(init_done[4]), .ksa_done(ksa_done[4]), .dec_done(dec_done[4]), .dec_valid(dec_valid[4]),
        .init_addr(IA), .init_data(ID), .init_wren(1'b1),
        .ksa_addr(KA), .ksa_data(KD), .ksa_wren(1'b1),
        .dec_addr(DA), .dec_data(DD), .dec_wren(1'b1),
        .s_addr(s_addr[4]), .s_data(s_data[4]), .s_wren(s_wren[4]), .secret_key(key4),
        .busy(busy[4]), .found(found[4]), .exhausted(exhausted[4]), .aborted(aborted[4])
`ifdef KEY_SEARCH_PERF_EN
        , .cycle_count(cc[4]), .keys_tried(kt4)
`endif
    );

    // Engine stub: each start is answered by a done pulse four cycles later.
    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            init_done[i] <= 1'b0;
            ksa_done[i]  <= 1'b0;
            dec_done[i]  <= 1'b0;
            dec_valid[i] <= 1'b0;
            if (rst) begin
                cnt[i] <= 0; ph[i] <= 0;
                n_init[i] <= 0; n_ksa[i] <= 0; n_dec[i] <= 0;
            end else if (init_start[i]) begin
                ph[i] <= 1; cnt[i] <= 3; n_init[i] <= n_init[i] + 1;
            end else if (ksa_start[i]) begin
                ph[i] <= 2; cnt[i] <= 3; n_ksa[i] <= n_ksa[i] + 1;
            end else if (dec_start[i]) begin
                ph[i] <= 3; cnt[i] <= 3; n_dec[i] <= n_dec[i] + 1;
                key_log[i][n_dec[i] % 8] <= skey[i];
            end else if (cnt[i] == 1) begin
                cnt[i] <= 0;
                if (ph[i] == 1) init_done[i] <= 1'b1;
                if (ph[i] == 2) ksa_done[i]  <= 1'b1;
                if (ph[i] == 3) begin
                    dec_done[i]  <= 1'b1;
                    dec_valid[i] <= (i == 0) && hit_en && (skey[i] == hit_key);
                end
            end else if (cnt[i] != 0) begin
                cnt[i] <= cnt[i] - 1;
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1; go = '0; stop = 1'b0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_go(input int i);
        go[i] = 1'b1;
        @(negedge clk);
        go[i] = 1'b0;
    endtask

    task automatic wait_term(input int i);
        int k = 0;
        while (!(found[i] | exhausted[i] | aborted[i]) && k < 3000) begin
            @(negedge clk); k++;
        end
        n_cmp++;
        if (k >= 3000) begin
            n_err++;
            $display("FAIL term_timeout inst %0d: no terminal flag in %0d cycles, required one", i, k);
        end
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < NI; i++) begin
            n_cmp++;
            if ({busy[i], found[i], exhausted[i], aborted[i], s_wren[i]} !== 5'b0 || s_addr[i] !== 8'h00
                || {init_start[i], ksa_start[i], dec_start[i]} !== 3'b0) begin
                n_err++;
                $display("FAIL reset_ctrl inst %0d: flags=%b wren=%b addr=%h starts=%b, required all 0", i,
                         {busy[i], found[i], exhausted[i], aborted[i]}, s_wren[i], s_addr[i],
                         {init_start[i], ksa_start[i], dec_start[i]});
            end
            n_cmp++;
            if (skey[i] !== exp_start[i]) begin
                n_err++;
                $display("FAIL reset_key inst %0d: key=%0d required %0d", i, skey[i], exp_start[i]);
            end
        end
    endtask

    task automatic test_hit();
        do_reset();
        hit_en = 1'b1; hit_key = 24'd5;
        pulse_go(0);
        wait_term(0);
        n_cmp++;
        if (found[0] !== 1'b1 || exhausted[0] !== 1'b0 || busy[0] !== 1'b0 || skey[0] !== 24'd5) begin
            n_err++;
            $display("FAIL hit_result: found=%b exh=%b busy=%b key=%0d, required 1 0 0 5",
                     found[0], exhausted[0], busy[0], skey[0]);
        end
        n_cmp++;
        if (n_init[0] != 6 || n_ksa[0] != 6 || n_dec[0] != 6) begin
            n_err++;
            $display("FAIL hit_pulses: init=%0d ksa=%0d dec=%0d, required 6 each", n_init[0], n_ksa[0], n_dec[0]);
        end
        pulse_go(0);
        repeat (5) @(negedge clk);
        n_cmp++;
        if (found[0] !== 1'b1 || n_init[0] != 6 || busy[0] !== 1'b0) begin
            n_err++;
            $display("FAIL hit_go_ignored: found=%b init=%0d busy=%b, required 1 6 0", found[0], n_init[0], busy[0]);
        end
        hit_en = 1'b0;
    endtask

    task automatic test_exhaust();
        do_reset();
        pulse_go(1);
        wait_term(1);
        n_cmp++;
        if (exhausted[1] !== 1'b1 || found[1] !== 1'b0 || skey[1] !== 24'd3 || n_dec[1] != 4) begin
            n_err++;
            $display("FAIL exhaust: exh=%b found=%b key=%0d dec=%0d, required 1 0 3 4",
                     exhausted[1], found[1], skey[1], n_dec[1]);
        end
`ifdef KEY_SEARCH_PERF_EN
        n_cmp++;
        if (kt[1] !== 24'd4) begin
            n_err++;
            $display("FAIL keys_tried: got %0d required 4", kt[1]);
        end
`endif
    endtask

    task automatic test_partition();
        do_reset();
        pulse_go(2);
        wait_term(2);
        n_cmp++;
        if (exhausted[2] !== 1'b1 || skey[2] !== 24'd9 || n_dec[2] != 3) begin
            n_err++;
            $display("FAIL partition: exh=%b key=%0d dec=%0d, required 1 9 3", exhausted[2], skey[2], n_dec[2]);
        end
        n_cmp++;
        if (key_log[2][0] !== 24'd1 || key_log[2][1] !== 24'd5 || key_log[2][2] !== 24'd9) begin
            n_err++;
            $display("FAIL partition_keys: %0d %0d %0d, required 1 5 9", key_log[2][0], key_log[2][1], key_log[2][2]);
        end
        pulse_go(3);
        n_cmp++;
        if (exhausted[3] !== 1'b1 || busy[3] !== 1'b0) begin
            n_err++;
            $display("FAIL start_above_limit: exh=%b busy=%b one cycle after go, required 1 0", exhausted[3], busy[3]);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (n_init[3] != 0 || skey[3] !== 24'd11) begin
            n_err++;
            $display("FAIL start_above_limit_pulses: init=%0d key=%0d, required 0 11", n_init[3], skey[3]);
        end
    endtask

    task automatic run_stop(input logic with_hit);
        int k = 0;
        do_reset();
        hit_en = with_hit; hit_key = 24'd2;
        pulse_go(0);
        while (!(ksa_start[0] && skey[0] == 24'd2) && k < 500) begin
            @(negedge clk); k++;
        end
        n_cmp++;
        if (k >= 500) begin
            n_err++;
            $display("FAIL stop_wait: ksa start for key 2 not seen in %0d cycles, required it", k);
        end
        @(negedge clk);
        stop = 1'b1;
        repeat (2) @(negedge clk);
        stop = 1'b0;
        wait_term(0);
        n_cmp++;
        if (found[0] !== with_hit || aborted[0] !== !with_hit || skey[0] !== 24'd2) begin
            n_err++;
            $display("FAIL stop_result hit=%b: found=%b aborted=%b key=%0d, required %b %b 2",
                     with_hit, found[0], aborted[0], skey[0], with_hit, !with_hit);
        end
        n_cmp++;
        if (n_init[0] != 3 || n_ksa[0] != 3 || n_dec[0] != 3) begin
            n_err++;
            $display("FAIL stop_pulses hit=%b: init=%0d ksa=%0d dec=%0d, required 3 each",
                     with_hit, n_init[0], n_ksa[0], n_dec[0]);
        end
        hit_en = 1'b0;
    endtask

    task automatic test_mux();
        int cur = 0;
        int k = 0;
        int bad = 0;
        logic [7:0] ea, ed;
        logic ew;
        do_reset();
        hit_en = 1'b1; hit_key = 24'd1;
        n_cmp++;
        if (s_wren[0] !== 1'b0 || s_addr[0] !== 8'h00) begin
            n_err++;
            $display("FAIL mux_idle: wren=%b addr=%h, required 0 00", s_wren[0], s_addr[0]);
        end
        go[0] = 1'b1;
        while (!found[0] && k < 500) begin
            @(negedge clk); go[0] = 1'b0; k++;
            if (init_start[0]) cur = 1;
            if (ksa_start[0])  cur = 2;
            if (dec_start[0])  cur = 3;
            case (cur)
                1: begin ea = IA; ed = ID; ew = 1'b1; end
                2: begin ea = KA; ed = KD; ew = 1'b1; end
                3: begin ea = DA; ed = DD; ew = 1'b1; end
                default: begin ea = 8'h00; ed = 8'h00; ew = 1'b0; end
            endcase
            n_cmp++;
            if (s_addr[0] !== ea || s_data[0] !== ed || s_wren[0] !== ew) begin
                n_err++; bad++;
                if (bad < 5) $display("FAIL mux_track cycle %0d: addr=%h data=%h wren=%b, required %h %h %b",
                                      k, s_addr[0], s_data[0], s_wren[0], ea, ed, ew);
            end
            if (cur == 3 && dec_done[0]) cur = 0;
        end
        @(negedge clk);
        n_cmp++;
        if (found[0] !== 1'b1 || s_wren[0] !== 1'b0 || s_addr[0] !== 8'h00) begin
            n_err++;
            $display("FAIL mux_terminal: found=%b wren=%b addr=%h, required 1 0 00", found[0], s_wren[0], s_addr[0]);
        end
        hit_en = 1'b0;
    endtask

    task automatic test_overflow();
        do_reset();
        pulse_go(4);
        wait_term(4);
        n_cmp++;
        if (exhausted[4] !== 1'b1 || skey[4] !== 24'd14 || n_dec[4] != 1) begin
            n_err++;
            $display("FAIL overflow: exh=%b key=%0d dec=%0d, required 1 14 1", exhausted[4], skey[4], n_dec[4]);
        end
    endtask

    task automatic test_reset_mid();
        int k = 0;
        do_reset();
        pulse_go(0);
        while (!(dec_start[0] && skey[0] == 24'd3) && k < 500) begin
            @(negedge clk); k++;
        end
        @(negedge clk);
        n_cmp++;
        if (busy[0] !== 1'b1 || s_addr[0] !== DA) begin
            n_err++;
            $display("FAIL reset_mid_pre: busy=%b addr=%h, required 1 33 (in decrypt wait)", busy[0], s_addr[0]);
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({busy[0], found[0], exhausted[0], aborted[0], s_wren[0]} !== 5'b0 || skey[0] !== 24'd0
            || s_addr[0] !== 8'h00) begin
            n_err++;
            $display("FAIL reset_mid: flags=%b wren=%b key=%0d addr=%h, required 0 0 0 00",
                     {busy[0], found[0], exhausted[0], aborted[0]}, s_wren[0], skey[0], s_addr[0]);
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_hit();
        test_exhaust();
        test_partition();
        run_stop(1'b0);
        run_stop(1'b1);
        test_mux();
        test_overflow();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
